// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the round controller and its timing helpers.
//   state_e        - round flow states (3-bit encoding)
//   CLK_HZ_DEFAULT - default pixel clock (800x600 timing)
//   MS_PER_S       - milliseconds per second
//   max_u          - elaboration-time max helper for counter sizing
package game_pkg;

  typedef enum logic [2:0] {
    S_MENU      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_ARM       = 3'd2,
    S_PLAY      = 3'd3,
    S_WIN       = 3'd4,
    S_LOST      = 3'd5
  } state_e;

  localparam int unsigned CLK_HZ_DEFAULT = 40_000_000;
  localparam int unsigned MS_PER_S       = 1000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_timer_ctrl_tick_gen.sv
// tick_gen: free-running millisecond prescaler.
//   clk         in  clock
//   rst_n       in  asynchronous reset, active-low
//   one_ms_tick out registered one-cycle pulse every TICKS_PER_MS cycles,
//                   asserted the cycle after the counter reaches TICKS_PER_MS-1
module tick_gen #(
  parameter int unsigned TICKS_PER_MS = 40_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic one_ms_tick
);

  localparam int unsigned CW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_MS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    tick_d = (cnt_q == LAST);
    cnt_d  = tick_d ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign one_ms_tick = tick_q;

endmodule

// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: round flow controller feeding the time bar overlay.
//   clk, rst_n     in  pixel clock, asynchronous active-low reset
//   btn_start      in  debounced start button (level)
//   vblnk_in       in  vertical blank from the timing pipeline
//   player_dead    in  one-cycle pulse, player fell
//   level_done     in  one-cycle pulse, player reached goal
//   elapsed        in  time bar expired (level)
//   one_ms_tick    out 1 ms pulse
//   bar_en         out time bar enable
//   bar_start      out one-cycle time bar start pulse (frame aligned)
//   countdown_val  out seconds remaining during countdown, else 0
//   game_active    out high while playing
//   round_won      out high on the win screen
//   round_lost     out high on the loss screen
module game_timer_ctrl
  import game_pkg::*;
#(
  parameter int unsigned CLK_HZ         = CLK_HZ_DEFAULT,
  parameter int unsigned TICKS_PER_MS   = CLK_HZ / 1000,
  parameter int unsigned COUNTDOWN_S    = 3,
  parameter int unsigned RESULT_HOLD_MS = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       vblnk_in,
  input  logic       player_dead,
  input  logic       level_done,
  input  logic       elapsed,
  output logic       one_ms_tick,
  output logic       bar_en,
  output logic       bar_start,
  output logic [3:0] countdown_val,
  output logic       game_active,
  output logic       round_won,
  output logic       round_lost
);

  localparam int unsigned MS_MAX = max_u(MS_PER_S - 1, RESULT_HOLD_MS);
  localparam int unsigned MS_W   = $clog2(MS_MAX + 1);
  localparam logic [MS_W-1:0] MS_WRAP = MS_W'(MS_PER_S - 1);
  localparam logic [MS_W-1:0] HOLD    = MS_W'(RESULT_HOLD_MS);
  localparam logic [3:0]      CD_LOAD = 4'(COUNTDOWN_S);

  state_e          state_q, state_d;
  logic [MS_W-1:0] ms_cnt_q, ms_cnt_d;
  logic [3:0]      sec_cnt_q, sec_cnt_d;
  logic            btn_q, vblnk_q;
  logic            press, vblnk_rise;

  logic            bar_en_q, bar_en_d;
  logic            bar_start_q, bar_start_d;
  logic [3:0]      cd_val_q, cd_val_d;
  logic            active_q, active_d;
  logic            won_q, won_d;
  logic            lost_q, lost_d;

  tick_gen #(
    .TICKS_PER_MS(TICKS_PER_MS)
  ) u_tick_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .one_ms_tick(one_ms_tick)
  );

  always_comb begin
    state_d     = state_q;
    ms_cnt_d    = ms_cnt_q;
    sec_cnt_d   = sec_cnt_q;
    bar_start_d = 1'b0;
    press       = btn_start & ~btn_q;
    vblnk_rise  = vblnk_in & ~vblnk_q;

    case (state_q)
      S_MENU: begin
        if (press) begin
          state_d   = S_COUNTDOWN;
          sec_cnt_d = CD_LOAD;
          ms_cnt_d  = '0;
        end
      end
      S_COUNTDOWN: begin
        if (one_ms_tick) begin
          if (ms_cnt_q == MS_WRAP) begin
            ms_cnt_d  = '0;
            sec_cnt_d = sec_cnt_q - 4'd1;
            if (sec_cnt_q == 4'd1) state_d = S_ARM;
          end else begin
            ms_cnt_d = ms_cnt_q + MS_W'(1);
          end
        end
      end
      S_ARM: begin
        if (vblnk_rise) begin
          state_d     = S_PLAY;
          bar_start_d = 1'b1;
        end
      end
      S_PLAY: begin
        // Clearing here means the hold counter is zero on entry to either result state.
        ms_cnt_d = '0;
        if (player_dead)     state_d = S_LOST;
        else if (level_done) state_d = S_WIN;
        else if (elapsed)    state_d = S_LOST;
      end
      S_WIN, S_LOST: begin
        if (press && (ms_cnt_q == HOLD)) begin
          state_d = S_MENU;
        end else if (one_ms_tick && (ms_cnt_q != HOLD)) begin
          ms_cnt_d = ms_cnt_q + MS_W'(1);
        end
      end
      default: state_d = S_MENU;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    bar_en_d = (state_d == S_COUNTDOWN) || (state_d == S_ARM) || (state_d == S_PLAY);
    cd_val_d = (state_d == S_COUNTDOWN) ? sec_cnt_d : '0;
    active_d = (state_d == S_PLAY);
    won_d    = (state_d == S_WIN);
    lost_d   = (state_d == S_LOST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_MENU;
      ms_cnt_q    <= '0;
      sec_cnt_q   <= '0;
      // Treat the button as already held so a press held through reset is not an edge.
      btn_q       <= 1'b1;
      vblnk_q     <= 1'b0;
      bar_en_q    <= 1'b0;
      bar_start_q <= 1'b0;
      cd_val_q    <= '0;
      active_q    <= 1'b0;
      won_q       <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ms_cnt_q    <= ms_cnt_d;
      sec_cnt_q   <= sec_cnt_d;
      btn_q       <= btn_start;
      vblnk_q     <= vblnk_in;
      bar_en_q    <= bar_en_d;
      bar_start_q <= bar_start_d;
      cd_val_q    <= cd_val_d;
      active_q    <= active_d;
      won_q       <= won_d;
      lost_q      <= lost_d;
    end
  end

  assign bar_en        = bar_en_q;
  assign bar_start     = bar_start_q;
  assign countdown_val = cd_val_q;
  assign game_active   = active_q;
  assign round_won     = won_q;
  assign round_lost    = lost_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// tb_game_timer_ctrl: self-checking bench for game_timer_ctrl with a
// behavioural round model (total-tick arithmetic) compared every cycle.
module tb_game_timer_ctrl;

  localparam int TPM  = 10;
  localparam int CDS  = 2;
  localparam int HOLD = 5;

  localparam int M_MENU = 0;
  localparam int M_CD   = 1;
  localparam int M_ARM  = 2;
  localparam int M_PLAY = 3;
  localparam int M_WIN  = 4;
  localparam int M_LOST = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_start = 1'b0;
  logic       vblnk_in = 1'b0;
  logic       player_dead = 1'b0;
  logic       level_done = 1'b0;
  logic       elapsed = 1'b0;
  logic       one_ms_tick, bar_en, bar_start, game_active, round_won, round_lost;
  logic [3:0] countdown_val;

  int tests = 0;
  int fails = 0;

  game_timer_ctrl #(
    .CLK_HZ        (10_000),
    .COUNTDOWN_S   (CDS),
    .RESULT_HOLD_MS(HOLD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_start    (btn_start),
    .vblnk_in     (vblnk_in),
    .player_dead  (player_dead),
    .level_done   (level_done),
    .elapsed      (elapsed),
    .one_ms_tick  (one_ms_tick),
    .bar_en       (bar_en),
    .bar_start    (bar_start),
    .countdown_val(countdown_val),
    .game_active  (game_active),
    .round_won    (round_won),
    .round_lost   (round_lost)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode plus cycle/tick totals.
  int mode = M_MENU;
  int m_cyc = 0;
  int m_ticks = 0;
  int m_btn_prev = 1;
  int m_vb_prev = 0;
  int m_tick = 0;
  int e_bar_start = 0;

  initial begin
    int press, rise, tk;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mode = M_MENU; m_cyc = 0; m_ticks = 0;
        m_btn_prev = 1; m_vb_prev = 0; m_tick = 0; e_bar_start = 0;
      end else begin
        tk    = m_tick;
        press = int'(btn_start && (m_btn_prev == 0));
        rise  = int'(vblnk_in && (m_vb_prev == 0));
        m_btn_prev = int'(btn_start);
        m_vb_prev  = int'(vblnk_in);
        m_cyc++;
        m_tick = int'((m_cyc % TPM) == 0);
        e_bar_start = 0;
        case (mode)
          M_MENU: if (press != 0) begin mode = M_CD; m_ticks = 0; end
          M_CD: if (tk != 0) begin
            m_ticks++;
            if (m_ticks == CDS * 1000) mode = M_ARM;
          end
          M_ARM: if (rise != 0) begin mode = M_PLAY; e_bar_start = 1; end
          M_PLAY: begin
            m_ticks = 0;
            if (player_dead)     mode = M_LOST;
            else if (level_done) mode = M_WIN;
            else if (elapsed)    mode = M_LOST;
          end
          default: begin
            if (press != 0 && m_ticks >= HOLD) mode = M_MENU;
            else if (tk != 0) m_ticks++;
          end
        endcase
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("tick", int'(one_ms_tick), m_tick);
    chk("bar_en", int'(bar_en), int'(mode == M_CD || mode == M_ARM || mode == M_PLAY));
    chk("bar_start", int'(bar_start), e_bar_start);
    chk("countdown_val", int'(countdown_val), (mode == M_CD) ? CDS - m_ticks / 1000 : 0);
    chk("game_active", int'(game_active), int'(mode == M_PLAY));
    chk("round_won", int'(round_won), int'(mode == M_WIN));
    chk("round_lost", int'(round_lost), int'(mode == M_LOST));
  end

  task automatic wait_ticks(input int target, inout int seen);
    int n = 0;
    while (seen < target && n < 100) begin
      @(negedge clk);
      seen += int'(one_ms_tick);
      n++;
    end
    chk("tick_wait_bound", int'(seen >= target), 1);
  endtask

  task automatic run_round(input int kind);
    int n, cd1, seen;
    btn_start = 1'b0; @(negedge clk);
    btn_start = 1'b1; @(negedge clk);
    chk("start_cd", int'(countdown_val), 2);
    chk("start_bar_en", int'(bar_en), 1);
    n = 0; cd1 = 0;
    while (countdown_val != 4'd0 && n < 25000) begin
      if (countdown_val == 4'd1) cd1++;
      btn_start   = ($urandom_range(0, 7) == 0);
      vblnk_in    = $urandom_range(0, 1) != 0;
      player_dead = ($urandom_range(0, 63) == 0);
      level_done  = ($urandom_range(0, 63) == 0);
      elapsed     = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      n++;
    end
    btn_start = 1'b0; vblnk_in = 1'b0;
    player_dead = 1'b0; level_done = 1'b0; elapsed = 1'b0;
    chk("cd_bound", int'(n < 25000), 1);
    chk("cd_sec1_cycles", cd1, 1000 * TPM);
    chk("arm_bar_en", int'(bar_en), 1);
    repeat (50) @(negedge clk);
    chk("arm_wait_inactive", int'(game_active), 0);
    vblnk_in = 1'b1;
    @(negedge clk);
    chk("bar_start_pulse", int'(bar_start), 1);
    chk("play_active", int'(game_active), 1);
    @(negedge clk);
    chk("bar_start_single", int'(bar_start), 0);
    repeat ($urandom_range(0, 30)) begin
      btn_start = $urandom_range(0, 1) != 0;
      vblnk_in  = $urandom_range(0, 1) != 0;
      @(negedge clk);
    end
    btn_start = 1'b0;
    case (kind)
      0: elapsed = 1'b1;
      1: begin player_dead = 1'b1; level_done = 1'b1; end
      default: begin level_done = 1'b1; elapsed = 1'b1; end
    endcase
    @(negedge clk);
    player_dead = 1'b0; level_done = 1'b0; elapsed = 1'b0;
    chk("result_lost", int'(round_lost), int'(kind != 2));
    chk("result_won", int'(round_won), int'(kind == 2));
    chk("result_bar_en", int'(bar_en), 0);
    seen = int'(one_ms_tick);
    wait_ticks(3, seen);
    btn_start = 1'b1; @(negedge clk);
    seen += int'(one_ms_tick);
    chk("early_press_ignored", int'(round_lost | round_won), 1);
    btn_start = 1'b0;
    wait_ticks(HOLD, seen);
    btn_start = 1'b1; @(negedge clk);
    chk("boundary_press_ignored", int'(round_lost | round_won), 1);
    btn_start = 1'b0; @(negedge clk);
    btn_start = 1'b1; @(negedge clk);
    chk("late_press_menu", int'(round_lost | round_won), 0);
    chk("menu_cd", int'(countdown_val), 0);
    btn_start = 1'b0;
  endtask

  initial begin
    btn_start = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tick", int'(one_ms_tick), 0);
    chk("rst_bar_en", int'(bar_en), 0);
    rst_n = 1'b1;
    repeat (9) @(negedge clk);
    chk("tick_cycle9", int'(one_ms_tick), 0);
    @(negedge clk);
    chk("tick_cycle10", int'(one_ms_tick), 1);
    @(negedge clk);
    chk("tick_cycle11", int'(one_ms_tick), 0);
    repeat (9) @(negedge clk);
    chk("tick_cycle20", int'(one_ms_tick), 1);
    chk("held_btn_menu", int'(countdown_val), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tick", int'(one_ms_tick), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("held_through_reset", int'(bar_en), 0);
    btn_start = 1'b0;
    repeat (2) @(negedge clk);
    btn_start = 1'b1;
    @(negedge clk);
    chk("press_to_cd", int'(countdown_val), 2);
    chk("press_bar_en", int'(bar_en), 1);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cd", int'(countdown_val), 0);
    chk("abort_bar_en", int'(bar_en), 0);
    @(negedge clk);
    rst_n = 1'b1;
    btn_start = 1'b0;
    @(negedge clk);
    for (int r = 0; r < 3; r++) run_round(r);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/game_timer_ctrl.md
Name: game_timer_ctrl

Overview:
Control stage directly upstream of the bottom-of-screen time bar overlay. It generates the 1 ms tick and drives the bar's enable and start inputs. It runs the round flow: menu, countdown, play, result. It consumes the bar's elapsed flag plus player events and reports round outcome to the rest of the game.

Parameters:
CLK_HZ, 40_000_000, pixel clock frequency (800x600 timing)
TICKS_PER_MS, CLK_HZ/1000, clk cycles per one_ms_tick
COUNTDOWN_S, 3, pre-round countdown length in seconds (1..9)
RESULT_HOLD_MS, 2000, minimum time result screen is held before a press is accepted

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous reset, active-low
btn_start  in  1  debounced start button, level
vblnk_in  in  1  vertical blank from the timing pipeline
player_dead  in  1  one-cycle pulse, player fell
level_done  in  1  one-cycle pulse, player reached goal
elapsed  in  1  time bar expired, level, from time bar
one_ms_tick  out  1  one-cycle pulse every TICKS_PER_MS cycles
bar_en  out  1  time bar module enable
bar_start  out  1  one-cycle time bar start pulse
countdown_val  out  4  seconds remaining in countdown, 0 outside COUNTDOWN
game_active  out  1  high in S_PLAY
round_won  out  1  high in S_WIN
round_lost  out  1  high in S_LOST

Behaviour:
- Reset: all outputs 0, FSM in S_MENU, all counters 0. Reset mid-round aborts immediately. bar_en=0 returns the bar to idle.
- All outputs are registered. Decisions use the previous-cycle registered samples btn_q/vblnk_q for edge detection.
- press = btn_start & ~btn_q. vblnk_rise = vblnk_in & ~vblnk_q.
- Tick prescaler:
  - free-running, counts 0..TICKS_PER_MS-1, wraps to 0.
  - one_ms_tick = 1 on the cycle after the counter reaches TICKS_PER_MS-1.
  - Never stops; independent of FSM.
- S_MENU: bar_en=0. On press: load sec_cnt=COUNTDOWN_S, ms_cnt=0, go to S_COUNTDOWN.
- S_COUNTDOWN:
  - bar_en=1, so the bar shows full.
  - countdown_val=sec_cnt.
  - Each tick: ms_cnt++. At ms_cnt==999 with a tick: ms_cnt=0, sec_cnt--.
  - When sec_cnt==1 wraps, go to S_ARM.
  - Presses are ignored.
- S_ARM:
  - bar_en=1.
  - Wait for vblnk_rise, then assert bar_start for exactly one cycle and go to S_PLAY.
  - The bar always starts on a frame boundary.
- S_PLAY: bar_en=1, game_active=1. Priority within one cycle: player_dead → S_LOST; else level_done → S_WIN; else elapsed → S_LOST.
- S_WIN / S_LOST:
  - bar_en=0.
  - ms_cnt cleared on entry and counts ticks, saturating at RESULT_HOLD_MS.
  - Presses before saturation are ignored.
  - A press after saturation goes to S_MENU.
- Illegal state encoding → S_MENU.
- Counter widths: $clog2 of the maximum value.
  - ms_cnt: 11 bits, covers max(999, RESULT_HOLD_MS).
  - sec_cnt: 4 bits.
- Latency:
  - press to S_COUNTDOWN: 1 cycle.
  - S_COUNTDOWN duration: COUNTDOWN_S*1000 ticks.
  - event to result state: 1 cycle.
- Button held through the menu: only the rising edge counts. A button held from reset does not start a round until it is released and pressed again.

Decomposition:
- Shared package game_pkg: FSM state encoding (S_MENU, S_COUNTDOWN, S_ARM, S_PLAY, S_WIN, S_LOST; 3 bits), default CLK_HZ, MS_PER_S=1000.
- One sub-module: tick_gen (prescaler, parameter TICKS_PER_MS, outputs one_ms_tick). Also reused by other timed blocks.

Test Plan:
- Bench parameters for all scenarios: CLK_HZ=10_000 (TICKS_PER_MS=10), COUNTDOWN_S=2, RESULT_HOLD_MS=5.
- Reset and tick: release rst_n → one_ms_tick pulses every 10 cycles. All other outputs stay 0 with no input. Assert rst_n=0 mid-count → tick counter and outputs return to 0 asynchronously.
- Countdown and start:
  - Press → countdown_val=2 for 1000 ticks, then 1 for 1000 ticks, then 0. bar_en=1 throughout.
  - Hold vblnk_in low 50 cycles, then raise it → exactly one bar_start pulse on the cycle after the rise.
  - game_active=1 afterwards.
- Timeout: in S_PLAY raise elapsed → round_lost=1 next cycle, bar_en=0. A press 3 ticks later is ignored. A press after 5 ticks → S_MENU.
- Simultaneous events: in S_PLAY pulse player_dead and level_done in the same cycle → round_lost=1, round_won=0. Repeat with level_done and elapsed together → round_won=1.
- Button held from reset: btn_start=1 before rst_n release → stays in S_MENU. Release, then press → S_COUNTDOWN one cycle after the edge.
